// File: rtl/a8_bus_sequencer_pkg.sv
// Shared types and defaults for the Atari 8-bit bus sequencer: state encoding,
// timing defaults and the register-port operation record.
`timescale 1ns/1ps
package a8_bus_sequencer_pkg;

  localparam logic [7:0] PAGE_DEFAULT       = 8'hD6;
  localparam int         ADDR_TICKS_DEFAULT = 20;
  localparam int         DATA_TICKS_DEFAULT = 50;
  localparam int         CNT_W_DEFAULT      = 8;

  typedef enum logic [3:0] {
    WAIT_LOW,
    WAIT_RISE,
    ADDR,
    RD_REQ,
    RD_LATCH,
    DRIVE,
    WR_WAIT,
    WR_COMMIT,
    IDLE_HI
  } seq_state_e;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       we;
    logic       re;
  } reg_op_t;

  localparam reg_op_t REG_OP_IDLE = '0;

  // States in which the bus owns the register port.
  function automatic logic is_bus_slot(input seq_state_e s);
    return (s == RD_REQ) || (s == WR_COMMIT);
  endfunction

endpackage

// File: rtl/a8_bus_sequencer_if.sv
// Bundle of A8 bus pins, register-file port and internal requester port.
// The sequencer uses the slave view; the surrounding system uses master.
`timescale 1ns/1ps
interface a8_bus_sequencer_if;
  logic        a8_clk;
  logic        a8_rst_n;
  logic [15:0] a8_addr;
  logic        a8_rw_n;
  logic [7:0]  a8_data_in;
  logic [7:0]  a8_data_out;
  logic        a8_data_oe;
  logic        a8_extsel_n;

  logic [7:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [7:0]  reg_rdata;

  logic        int_req;
  logic        int_we;
  logic [7:0]  int_addr;
  logic [7:0]  int_wdata;
  logic        int_gnt;

  modport slave (
    input  a8_clk, a8_rst_n, a8_addr, a8_rw_n, a8_data_in,
    output a8_data_out, a8_data_oe, a8_extsel_n,
    output reg_addr, reg_wdata, reg_we, reg_re,
    input  reg_rdata,
    input  int_req, int_we, int_addr, int_wdata,
    output int_gnt
  );

  modport master (
    output a8_clk, a8_rst_n, a8_addr, a8_rw_n, a8_data_in,
    input  a8_data_out, a8_data_oe, a8_extsel_n,
    input  reg_addr, reg_wdata, reg_we, reg_re,
    output reg_rdata,
    output int_req, int_we, int_addr, int_wdata,
    input  int_gnt
  );
endinterface

// File: rtl/a8_bus_sequencer_edge_sync.sv
// Two-flop synchroniser for an asynchronous A8 signal, followed by a
// one-cycle edge detector on the synchronised value.
`timescale 1ns/1ps
module a8_edge_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk200,
  input  logic rst,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk200) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/a8_bus_sequencer.sv
// Tracks the A8 phi2 cycle in the clk200 domain, services reads/writes to the
// register page and shares the single register port with an internal requester.
`timescale 1ns/1ps
module a8_bus_sequencer
  import a8_bus_sequencer_pkg::*;
#(
  parameter logic [7:0] PAGE       = PAGE_DEFAULT,
  parameter int         ADDR_TICKS = ADDR_TICKS_DEFAULT,
  parameter int         DATA_TICKS = DATA_TICKS_DEFAULT,  // must exceed ADDR_TICKS+2
  parameter int         CNT_W      = CNT_W_DEFAULT
) (
  input logic               clk200,
  input logic               rst,
  a8_bus_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] ADDR_CNT = CNT_W'(ADDR_TICKS);
  localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(DATA_TICKS);

  logic [1:0] async_vec;
  logic [1:0] sync_vec;
  logic [1:0] rise_vec;
  logic [1:0] fall_vec;

  assign async_vec = {bus.a8_rst_n, bus.a8_clk};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      a8_edge_sync #(.RESET_VAL(1'b0)) u_sync (
        .clk200 (clk200),
        .rst    (rst),
        .async_i(async_vec[gi]),
        .sync_o (sync_vec[gi]),
        .rise_o (rise_vec[gi]),
        .fall_o (fall_vec[gi])
      );
    end
  endgenerate

  logic phi2s;
  logic a8_rsts;
  logic phi2_rise;
  logic phi2_fall;
  logic rst_edges_unused;

  assign phi2s            = sync_vec[0];
  assign a8_rsts          = sync_vec[1];
  assign phi2_rise        = rise_vec[0];
  assign phi2_fall        = fall_vec[0];
  assign rst_edges_unused = rise_vec[1] ^ fall_vec[1];

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       dout_q, dout_d;
  logic             oe_q, oe_d;

  reg_op_t bus_op;
  reg_op_t port_op;
  logic    bus_slot;
  logic    int_gnt_c;

  always_ff @(posedge clk200) begin
    if (rst) begin
      state_q <= WAIT_LOW;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
    end
  end

  // Phase counter: zeroed on the rise that opens a cycle, saturating while phi2 is high.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == WAIT_RISE && phi2_rise) begin
      cnt_d = '0;
    end else if (phi2s && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    bus_op  = REG_OP_IDLE;

    if (!a8_rsts) begin
      state_d = WAIT_LOW;
      oe_d    = 1'b0;
    end else begin
      unique case (state_q)
        WAIT_LOW: begin
          if (!phi2s) state_d = WAIT_RISE;
        end
        WAIT_RISE: begin
          if (phi2_rise) state_d = ADDR;
        end
        ADDR: begin
          if (phi2_fall) begin
            state_d = WAIT_RISE;
          end else if (cnt_q == ADDR_CNT) begin
            addr_d = bus.a8_addr[7:0];
            if (bus.a8_addr[15:8] != PAGE) state_d = IDLE_HI;
            else if (bus.a8_rw_n)          state_d = RD_REQ;
            else                           state_d = WR_WAIT;
          end
        end
        RD_REQ: begin
          bus_op.addr = addr_q;
          bus_op.re   = 1'b1;
          state_d     = RD_LATCH;
        end
        RD_LATCH: begin
          dout_d  = bus.reg_rdata;
          oe_d    = 1'b1;
          state_d = DRIVE;
        end
        DRIVE: begin
          if (phi2_fall) begin
            oe_d    = 1'b0;
            state_d = WAIT_RISE;
          end
        end
        WR_WAIT: begin
          if (phi2_fall) begin
            state_d = WAIT_RISE;
          end else if (cnt_q == DATA_CNT) begin
            wdata_d = bus.a8_data_in;
            state_d = WR_COMMIT;
          end
        end
        WR_COMMIT: begin
          bus_op.addr  = addr_q;
          bus_op.wdata = wdata_q;
          bus_op.we    = 1'b1;
          state_d      = IDLE_HI;
        end
        IDLE_HI: begin
          if (phi2_fall) state_d = WAIT_RISE;
        end
        default: state_d = WAIT_LOW;
      endcase
    end
  end

  // Fixed-priority port mux: the bus slot always wins, so the A8 never waits.
  assign bus_slot = is_bus_slot(state_q) && a8_rsts;

  always_comb begin
    port_op   = REG_OP_IDLE;
    int_gnt_c = 1'b0;
    if (!rst) begin
      if (bus_slot) begin
        port_op = bus_op;
      end else if (bus.int_req) begin
        port_op.addr  = bus.int_addr;
        port_op.wdata = bus.int_wdata;
        port_op.we    = bus.int_we;
        port_op.re    = ~bus.int_we;
        int_gnt_c     = 1'b1;
      end
    end
  end

  assign bus.reg_addr    = port_op.addr;
  assign bus.reg_wdata   = port_op.wdata;
  assign bus.reg_we      = port_op.we;
  assign bus.reg_re      = port_op.re;
  assign bus.int_gnt     = int_gnt_c;

  assign bus.a8_data_out = dout_q;
  assign bus.a8_data_oe  = oe_q;
  assign bus.a8_extsel_n = !(state_q inside {RD_REQ, RD_LATCH, DRIVE});

endmodule

// File: tb/tb_a8_bus_sequencer.sv
// Directed and randomized bus cycles against a byte-level model of the register
// page, with a concurrent internal requester sharing the register port.
`timescale 1ns/1ps
module tb_a8_bus_sequencer;
  import a8_bus_sequencer_pkg::*;

  localparam int      DT   = DATA_TICKS_DEFAULT;
  localparam realtime TCLK = 5.0;
  localparam realtime HALF = 288.0;

  logic clk200 = 1'b0;
  logic rst    = 1'b1;

  a8_bus_sequencer_if bus_if();

  a8_bus_sequencer dut (
    .clk200(clk200),
    .rst   (rst),
    .bus   (bus_if.slave)
  );

  initial forever #2.5 clk200 = ~clk200;

  int vectors     = 0;
  int miscompares = 0;

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 7 + 3);
  endfunction

  // Register file: one port, registered read data.
  logic [7:0] regmem [256];
  logic       mem_loaded = 1'b0;
  always @(posedge clk200) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) regmem[i] <= init_val(i);
      bus_if.reg_rdata <= 8'h00;
      mem_loaded <= 1'b1;
    end else begin
      if (bus_if.reg_we) regmem[bus_if.reg_addr] <= bus_if.reg_wdata;
      if (bus_if.reg_re) bus_if.reg_rdata <= regmem[bus_if.reg_addr];
    end
  end

  // Monitor: running totals sampled mid-cycle; bus cycles compare deltas.
  int         mon_we = 0, mon_re = 0, mon_oe = 0, mon_oe_bad = 0, mon_sel = 0, mon_blk = 0;
  logic [7:0] mon_we_addr, mon_we_data, mon_re_addr;
  realtime    mon_we_t, mon_oe_t, mon_sel_t;
  logic [7:0] exp_rd_data = 8'h00;
  always @(negedge clk200) begin
    if (bus_if.reg_we === 1'b1 && bus_if.int_gnt !== 1'b1) begin
      mon_we++;
      mon_we_addr = bus_if.reg_addr;
      mon_we_data = bus_if.reg_wdata;
      mon_we_t    = $realtime;
    end
    if (bus_if.reg_re === 1'b1 && bus_if.int_gnt !== 1'b1) begin
      mon_re++;
      mon_re_addr = bus_if.reg_addr;
    end
    if (bus_if.a8_data_oe !== 1'b0) begin
      mon_oe++;
      mon_oe_t = $realtime;
      if (bus_if.a8_data_out !== exp_rd_data) mon_oe_bad++;
    end
    if (bus_if.a8_extsel_n !== 1'b1) begin
      mon_sel++;
      mon_sel_t = $realtime;
    end
    if (bus_if.int_req === 1'b1 && bus_if.int_gnt !== 1'b1) mon_blk++;
  end

  // Internal requester: 0 idle, 1 random traffic in 80..FE, 2 continuous write.
  int         int_mode = 0;
  logic [7:0] int_ref [256];
  logic [8:0] int_obs_q[$];
  logic [8:0] int_exp_q[$];
  initial begin
    logic       gnt_seen;
    logic       pend_rd;
    logic [7:0] pend_exp;
    int         wait_cnt;
    for (int i = 0; i < 256; i++) int_ref[i] = init_val(i);
    bus_if.int_req   = 1'b0;
    bus_if.int_we    = 1'b0;
    bus_if.int_addr  = 8'h00;
    bus_if.int_wdata = 8'h00;
    pend_rd  = 1'b0;
    pend_exp = 8'h00;
    wait_cnt = 0;
    forever begin
      @(negedge clk200);
      if (pend_rd) begin
        int_obs_q.push_back({1'b0, bus_if.reg_rdata});
        int_exp_q.push_back({1'b0, pend_exp});
        pend_rd = 1'b0;
      end
      gnt_seen = bus_if.int_req && bus_if.int_gnt;
      @(posedge clk200);
      #1;
      if (gnt_seen) begin
        if (bus_if.int_we) int_ref[bus_if.int_addr] = bus_if.int_wdata;
        else begin
          pend_rd  = 1'b1;
          pend_exp = int_ref[bus_if.int_addr];
        end
        wait_cnt = 0;
        if (int_mode != 2) bus_if.int_req = 1'b0;
      end else if (bus_if.int_req) begin
        wait_cnt++;
        if (wait_cnt > 100) begin
          int_obs_q.push_back(9'h100);
          int_exp_q.push_back(9'h000);
          bus_if.int_req = 1'b0;
          wait_cnt = 0;
        end
      end
      if (int_mode == 2) begin
        bus_if.int_req   = 1'b1;
        bus_if.int_we    = 1'b1;
        bus_if.int_addr  = 8'h90;
        bus_if.int_wdata = 8'hC3;
      end else if (int_mode == 1 && !bus_if.int_req && $urandom_range(0, 2) == 0) begin
        bus_if.int_req   = 1'b1;
        bus_if.int_we    = 1'($urandom_range(0, 1));
        bus_if.int_addr  = 8'(8'h80 + $urandom_range(0, 126));
        bus_if.int_wdata = 8'($urandom);
      end
    end
  end

  logic [7:0] ref_mem [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: normal cycle, 1: a8_rst_n pulse mid-cycle, 2: rst pulse mid-cycle
  task automatic bus_cycle(input logic [15:0] addr, input logic rw_n,
                           input logic [7:0] wdata, input int mode);
    int      we0, re0, oe0, bad0, sel0;
    realtime t_rise, t_fall, d_we, d_oe, d_sel;
    logic    hit, wr, rd;
    logic [7:0] lo;
    we0 = mon_we; re0 = mon_re; oe0 = mon_oe; bad0 = mon_oe_bad; sel0 = mon_sel;
    lo  = addr[7:0];
    hit = (addr[15:8] == 8'hD6);
    bus_if.a8_addr    = addr;
    bus_if.a8_rw_n    = rw_n;
    bus_if.a8_data_in = wdata;
    exp_rd_data       = ref_mem[lo];
    bus_if.a8_clk     = 1'b1;
    t_rise            = $realtime;
    if (mode == 1) begin
      #100 bus_if.a8_rst_n = 1'b0;
      #(HALF - 100);
    end else if (mode == 2) begin
      #150 rst = 1'b1;
      #15  rst = 1'b0;
      #(HALF - 165);
    end else begin
      #(HALF);
    end
    bus_if.a8_clk = 1'b0;
    t_fall        = $realtime;
    if (mode == 1) begin
      #100 bus_if.a8_rst_n = 1'b1;
      #(HALF - 100);
    end else begin
      #(HALF);
    end

    wr = (mode == 0) && hit && !rw_n;
    rd = (mode == 0) && hit && rw_n;
    chk($sformatf("we_count %h", addr), mon_we - we0, wr);
    chk($sformatf("re_count %h", addr), mon_re - re0, rd);
    if (wr) begin
      d_we = mon_we_t - t_rise;
      chk($sformatf("we_addr %h", addr), mon_we_addr, lo);
      chk($sformatf("we_data %h", addr), mon_we_data, wdata);
      chk($sformatf("we_time %h", addr),
          (d_we >= (DT + 1) * TCLK) && (d_we <= (DT + 5) * TCLK), 1);
      ref_mem[lo] = wdata;
    end
    if (rd) begin
      d_oe  = mon_oe_t - t_fall;
      d_sel = mon_sel_t - t_fall;
      chk($sformatf("re_addr %h", addr), mon_re_addr, lo);
      chk($sformatf("oe_seen %h", addr), (mon_oe - oe0) > 0, 1);
      chk($sformatf("rd_data %h", addr), mon_oe_bad - bad0, 0);
      chk($sformatf("oe_end %h", addr), (d_oe > 0.0) && (d_oe <= 3 * TCLK + 2.5), 1);
      chk($sformatf("sel_end %h", addr), (d_sel > 0.0) && (d_sel <= 3 * TCLK + 2.5), 1);
    end else begin
      chk($sformatf("oe_idle %h", addr), mon_oe - oe0, 0);
      chk($sformatf("sel_idle %h", addr), mon_sel - sel0, 0);
    end
    $display("cycle addr=%h rw_n=%0d wdata=%h mode=%0d we=%0d re=%0d oe_cycles=%0d",
             addr, rw_n, wdata, mode, mon_we - we0, mon_re - re0, mon_oe - oe0);
  endtask

  initial begin
    int         blk0;
    logic [15:0] a;
    logic [7:0]  hi;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    bus_if.a8_clk     = 1'b0;
    bus_if.a8_rst_n   = 1'b1;
    bus_if.a8_addr    = 16'h0000;
    bus_if.a8_rw_n    = 1'b1;
    bus_if.a8_data_in = 8'h00;
    rst = 1'b1;

    repeat (3) @(posedge clk200);
    @(negedge clk200);
    chk("rst_oe",      bus_if.a8_data_oe,  1'b0);
    chk("rst_dout",    bus_if.a8_data_out, 8'h00);
    chk("rst_extsel",  bus_if.a8_extsel_n, 1'b1);
    chk("rst_we",      bus_if.reg_we,      1'b0);
    chk("rst_re",      bus_if.reg_re,      1'b0);
    chk("rst_gnt",     bus_if.int_gnt,     1'b0);
    rst = 1'b0;
    #301.3;

    bus_cycle(16'hD600, 1'b0, 8'h90, 0);
    bus_cycle(16'h0600, 1'b1, 8'h70, 0);
    bus_cycle(16'hD605, 1'b0, 8'h5A, 0);
    bus_cycle(16'hD605, 1'b1, 8'h00, 0);
    bus_cycle(16'hD6FF, 1'b0, 8'h3C, 0);
    bus_cycle(16'hD6FF, 1'b1, 8'h00, 0);

    int_mode = 2;
    #23.1;
    blk0 = mon_blk;
    bus_cycle(16'hD620, 1'b0, 8'hA5, 0);
    chk("int_blocked", mon_blk - blk0, 1);
    int_mode = 0;
    #23.1;

    bus_cycle(16'hD610, 1'b0, 8'h11, 1);
    bus_cycle(16'hD610, 1'b0, 8'h22, 0);
    bus_cycle(16'hD610, 1'b1, 8'h00, 0);
    bus_cycle(16'hD611, 1'b0, 8'h33, 2);
    bus_cycle(16'hD611, 1'b1, 8'h00, 0);
    bus_cycle(16'hD620, 1'b1, 8'h00, 0);

    int_mode = 1;
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        hi = 8'($urandom_range(0, 255));
        if (hi == 8'hD6) hi = 8'hD7;
        a = {hi, 8'($urandom_range(0, 255))};
      end else begin
        a = {8'hD6, 8'($urandom_range(0, 127))};
      end
      bus_cycle(a, 1'($urandom_range(0, 1)), 8'($urandom), 0);
    end
    int_mode = 0;
    #200;

    chk("int_reads_seen", int_obs_q.size() > 0, 1);
    for (int k = 0; k < int_obs_q.size(); k++) begin
      chk($sformatf("int_rd %0d", k), int_obs_q[k], int_exp_q[k]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/a8_bus_sequencer.md
Name: a8_bus_sequencer

Overview:
- Runs in the clk200 domain and tracks the Atari 8-bit bus cycle by oversampling a8_clk (phi2).
- Schedules address and data sample points within each bus cycle and decodes accesses to the pixl register page ($D6xx).
- Sequences register-file reads and writes for those accesses and drives read data back onto the bus.
- Arbitrates the single register-file port between the A8 bus (fixed priority) and an internal requester.

Parameters:
- PAGE, 8'hD6, high address byte that selects the register window.
- ADDR_TICKS, 20, clk200 ticks after synchronised phi2 rise at which a8_addr/a8_rw_n are captured.
- DATA_TICKS, 50, clk200 ticks after synchronised phi2 rise at which a8_data_in is captured on writes; must be greater than ADDR_TICKS+2.
- CNT_W, 8, width of the phase counter; the counter saturates at all-ones.

Ports:
- clk200  in  1  system clock, 200 MHz.
- rst  in  1  synchronous reset, active-high.
- a8_clk  in  1  phi2, asynchronous; passes through a 2-flop synchroniser.
- a8_rst_n  in  1  Atari reset, asynchronous, active-low; passes through a 2-flop synchroniser.
- a8_addr  in  16  bus address.
- a8_rw_n  in  1  1 = read, 0 = write.
- a8_data_in  in  8  bus write data.
- a8_data_out  out  8  bus read data.
- a8_data_oe  out  1  read-data output enable.
- a8_extsel_n  out  1  active-low external select, asserted for page-hit reads.
- reg_addr  out  8  register-file address.
- reg_wdata  out  8  register-file write data.
- reg_we  out  1  register-file write strobe, 1 cycle.
- reg_re  out  1  register-file read strobe, 1 cycle.
- reg_rdata  in  8  register-file read data, valid 1 cycle after reg_re.
- int_req  in  1  internal requester wants the port this cycle.
- int_we  in  1  internal request is a write.
- int_addr  in  8  internal address.
- int_wdata  in  8  internal write data.
- int_gnt  out  1  internal request is accepted this cycle.

Behaviour:
Reset and synchronisation
- Synchronous reset values: state = WAIT_LOW, phase counter 0, a8_data_out 0, a8_data_oe 0, a8_extsel_n 1, int_gnt 0, and reg_we/reg_re/reg_addr/reg_wdata all 0.
- phi2s and a8_rsts are the synchronised versions of a8_clk and a8_rst_n.
- rise = phi2s & ~phi2s_d. fall = ~phi2s & phi2s_d.

State machine
- WAIT_LOW: go to WAIT_RISE when phi2s == 0.
- WAIT_RISE: on rise, clear the counter and go to ADDR.
- ADDR: when counter == ADDR_TICKS, register a8_addr and a8_rw_n, and compute hit = (addr[15:8] == PAGE).
  - Miss → IDLE_HI.
  - Hit & read → RD_REQ.
  - Hit & write → WR_WAIT.
- RD_REQ: bus slot with reg_re = 1 and reg_addr = addr[7:0] → RD_LATCH.
- RD_LATCH: a8_data_out <= reg_rdata; a8_data_oe <= 1 → DRIVE.
- DRIVE: hold data; on fall, set a8_data_oe <= 0 → WAIT_RISE.
- WR_WAIT: at counter == DATA_TICKS, register a8_data_in → WR_COMMIT.
- WR_COMMIT: bus slot with reg_we = 1 and reg_addr/reg_wdata from the captured values → IDLE_HI.
- IDLE_HI: on fall → WAIT_RISE.

Counter and select
- The counter increments every clk200 cycle while phi2s is high and saturates.
- a8_extsel_n = 0 from RD_REQ through DRIVE, and 1 otherwise.

Arbitration
- The register port is a combinational mux.
- In a bus slot (RD_REQ or WR_COMMIT), the port carries the bus operation and int_gnt = 0.
- Otherwise, if int_req is high, the port carries int_addr/int_wdata with reg_we = int_we and reg_re = ~int_we, and int_gnt = 1.
- Otherwise the port is idle with all strobes 0.
- Internal read data appears on reg_rdata 1 cycle after the grant.
- The bus is never stalled.
- The internal requester holds its request until it sees int_gnt.

Boundary conditions
- fall before ADDR_TICKS, or before DATA_TICKS on a hit write: abandon the cycle, issue no strobe, go to WAIT_RISE.
- a8_rsts == 0 in any state: set a8_data_oe <= 0 and a8_extsel_n <= 1, cancel any pending bus slot, go to WAIT_LOW. Internal arbitration continues.
- Page hit with addr[7:0] = FF is a valid access; there is no special wrap case.
- rst asserted mid-cycle: reset values apply on the next edge and the in-flight access is dropped.

Decomposition:
- pixl_pkg holds the state encoding, the default PAGE, ADDR_TICKS/DATA_TICKS, and the register-port op struct (addr, wdata, we, re).
- Sub-module a8_edge_sync: 2-flop synchroniser plus edge detector, instantiated for a8_clk and a8_rst_n.

Test Plan:
- Reset: hold rst high for 3 cycles → a8_data_oe = 0, a8_extsel_n = 1, reg_we = 0, reg_re = 0, int_gnt = 0.
- Write $D600 = 0x90 (a8_rw_n = 0, a8_clk half-period 288 ns) → exactly one reg_we pulse with reg_addr = 0x00 and reg_wdata = 0x90, at DATA_TICKS+1..+3 ticks after the phi2 edge.
- Read $0600 with data 0x70 → no reg_we or reg_re; a8_data_oe stays 0 and a8_extsel_n stays 1 for the whole cycle.
- Read $D605 with reg_rdata = 0x5A → one reg_re pulse with reg_addr = 0x05; a8_data_out = 0x5A with a8_data_oe = 1 until at most 3 ticks after phi2 falls; a8_extsel_n = 0 over the same window.
- int_req held high with int_we = 1 during a $D6 write → int_gnt = 0 only in the WR_COMMIT cycle and 1 in all other cycles; the bus write lands once.
- a8_rst_n driven low 100 ns after phi2 rise on a $D610 write → no reg_we; state returns to WAIT_LOW; the next normal cycle completes correctly.
